f1_random_delay: RTL and testbench



---
 rtl/f1_random_delay.sv | 121 ++++++++++++
 tb/tb_f1_random_delay.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/f1_random_delay.sv
// f1_random_delay: pseudo-random hold-off timer for the F1 start-light sequencer.
// A 14-bit Fibonacci LFSR (x^14+x^5+x^3+x+1) free-runs while en_lfsr is high.
// On an accepted start it is sampled to load a millisecond down-counter.
// time_out pulses for one cycle when the counter expires.
// Optional build macro: F1_DELAY_FAST_SIM_EN -- counter decrements every sysclk
// instead of on tick, so the delay is measured in cycles (simulation only).
module f1_random_delay #(
    parameter int LFSR_W    = 14,   // feedback taps are fixed at bits 13/4/2/0
    parameter int RAND_BITS = 12,   // must be <= LFSR_W
    parameter int MIN_DELAY = 250,  // must be >= 1
    parameter int CNT_W     = 14    // must hold MIN_DELAY + 2**RAND_BITS - 1
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en_lfsr,
    input  logic             start_delay,
    output logic             time_out,
    output logic             busy,
    output logic [CNT_W-1:0] delay_ms
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  sample;
    logic              armed;
    logic              accept;
    logic              dec;
    logic              fb;

    assign fb = lfsr[LFSR_W-1] ^ lfsr[4] ^ lfsr[2] ^ lfsr[0];

    // The sample uses the LFSR value of the accepting cycle, before any same-cycle shift.
    assign sample = CNT_W'(MIN_DELAY) + CNT_W'(lfsr[RAND_BITS-1:0]);

    // A held-high start_delay fires only once: armed re-arms after start_delay drops.
    assign accept = start_delay && (state == IDLE) && armed;

`ifdef F1_DELAY_FAST_SIM_EN
    // Fast simulation: count sysclk cycles, tick is ignored.
    assign dec = 1'b1;
`else
    assign dec = tick;
`endif

    // Next LFSR value, with lock-up guard that reloads the seed from all-zero.
    always_comb begin
        lfsr_next = lfsr;
        if (lfsr == '0)
            lfsr_next = LFSR_W'(1);
        else if (en_lfsr)
            lfsr_next = {lfsr[LFSR_W-2:0], fb};
    end

    // LFSR register, independent of the FSM.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst)
            lfsr <= LFSR_W'(1);
        else
            lfsr <= lfsr_next;
    end

    // Edge qualifier for start_delay: cleared on accept, set whenever the request is low.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst)
            armed <= 1'b1;
        else if (!start_delay)
            armed <= 1'b1;
        else if (accept)
            armed <= 1'b0;
    end

    // Delay FSM with registered time_out / busy / delay_ms.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            delay_ms <= '0;
            time_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            time_out <= 1'b0;
            case (state)
                IDLE: begin
                    // A tick coinciding with the accept is deliberately not counted.
                    if (accept) begin
                        count    <= sample;
                        delay_ms <= sample;
                        busy     <= 1'b1;
                        state    <= COUNT;
                    end
                end
                COUNT: begin
                    if (dec) begin
                        if (count == CNT_W'(1)) begin
                            count    <= '0;
                            time_out <= 1'b1;
                            state    <= DONE;
                        end else begin
                            count <= count - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // time_out is high for exactly this cycle; busy drops next.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f1_random_delay.sv
// Self-checking bench for f1_random_delay: table of delay scenarios plus
// hand-written reset-mid-delay (and fast-sim, when the macro is defined) sequences.
module tb_f1_random_delay;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        en_lfsr = 1'b0;
    logic        start_delay = 1'b0;
    logic        time_out;
    logic        busy;
    logic [13:0] delay_ms;

    int passed = 0;
    int total  = 0;

    f1_random_delay dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .tick        (tick),
        .en_lfsr     (en_lfsr),
        .start_delay (start_delay),
        .time_out    (time_out),
        .busy        (busy),
        .delay_ms    (delay_ms)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        string name;
        int    lfsr_steps;      // en_lfsr cycles before the start
        bit    tick_at_accept;  // tick asserted in the accept cycle
        int    hold;            // cycles start_delay stays high, accept cycle included
        int    repulse;         // post-accept cycle for an extra start pulse, -1 none
        int    exp_delay;
        int    exp_ticks;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Inputs change at negedge; outputs are sampled at the following negedge.
    task automatic step();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; en_lfsr = 1'b0; start_delay = 1'b0;
        step();
        rst = 1'b0;
    endtask

    int ticks, pulses, to_at, early, fall_ok, late_busy, after, edges;
    bit prev_to;

    initial begin
        // LFSR from seed 1: 1 -> 0x3 -> 0x7, so delays 251, 253, 257.
        vecs[0] = '{"held5",        0, 1'b0, 5,      -1,  251, 251};
        vecs[1] = '{"lfsr_step1",   1, 1'b0, 1,      -1,  253, 253};
        vecs[2] = '{"tick_accept",  0, 1'b1, 1,      -1,  251, 251};
        vecs[3] = '{"repulse",      0, 1'b0, 1,      300, 251, 251};
        vecs[4] = '{"held_forever", 2, 1'b0, 100000, -1,  257, 257};

        @(negedge sysclk);
        check("reset/time_out", int'(time_out), 0);
        check("reset/busy", int'(busy), 0);
        check("reset/delay_ms", int'(delay_ms), 0);

`ifdef F1_DELAY_FAST_SIM_EN
        // Fast sim: counter runs on sysclk, tick held low; time_out after 251 edges past accept.
        do_reset();
        start_delay = 1'b1;
        step();
        start_delay = 1'b0;
        check("fast/delay_ms", int'(delay_ms), 251);
        edges = 0; to_at = -1;
        for (int k = 0; k < 400; k++) begin
            step();
            edges++;
            if (time_out) begin
                to_at = edges;
                break;
            end
        end
        check("fast/time_out_edge", to_at, 251);
        step();
        check("fast/busy_fall", int'(busy), 0);
`else
        for (int v = 0; v < 5; v++) begin
            do_reset();
            en_lfsr = 1'b1;
            repeat (vecs[v].lfsr_steps) step();
            en_lfsr = 1'b0;
            start_delay = 1'b1;
            tick = vecs[v].tick_at_accept;
            step();
            check({vecs[v].name, "/accept_busy"}, int'(busy), 1);
            check({vecs[v].name, "/accept_delay"}, int'(delay_ms), vecs[v].exp_delay);

            ticks = 0; pulses = 0; to_at = -1; early = 0; fall_ok = 0;
            late_busy = 0; after = 0; prev_to = 1'b0;
            for (int k = 0; k < 1400; k++) begin
                tick = (k % 4 == 3);
                start_delay = (k < vecs[v].hold - 1) || (k == vecs[v].repulse);
                step();
                if (tick) ticks++;
                if (prev_to) fall_ok = (busy == 1'b0) ? 1 : 0;
                else if (after > 0 && busy) late_busy = 1;
                if (time_out) begin
                    pulses++;
                    to_at = ticks;
                    if (!busy) early = 1;
                end else if (pulses == 0 && !busy) begin
                    early = 1;
                end
                if (pulses > 0 && !time_out) after++;
                prev_to = time_out;
                if (after >= 20) break;
            end
            tick = 1'b0;
            start_delay = 1'b0;
            check({vecs[v].name, "/pulses"}, pulses, 1);
            check({vecs[v].name, "/time_out_tick"}, to_at, vecs[v].exp_ticks);
            check({vecs[v].name, "/busy_fall"}, fall_ok, 1);
            check({vecs[v].name, "/busy_early_drop"}, early, 0);
            check({vecs[v].name, "/retrigger"}, late_busy, 0);
            check({vecs[v].name, "/final_delay"}, int'(delay_ms), vecs[v].exp_delay);
        end

        // Reset at count=100 (151 ticks into 251): outputs clear asynchronously, LFSR reseeds.
        do_reset();
        start_delay = 1'b1;
        step();
        start_delay = 1'b0;
        en_lfsr = 1'b1;
        ticks = 0;
        for (int k = 0; k < 700 && ticks < 151; k++) begin
            tick = (k % 4 == 3);
            step();
            if (tick) ticks++;
        end
        tick = 1'b0;
        en_lfsr = 1'b0;
        check("rstmid/ticks_reached", ticks, 151);
        check("rstmid/busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rstmid/async_busy", int'(busy), 0);
        check("rstmid/async_delay", int'(delay_ms), 0);
        check("rstmid/async_time_out", int'(time_out), 0);
        @(negedge sysclk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 1100; k++) begin
            tick = (k % 4 == 3);
            step();
            if (time_out) pulses++;
        end
        tick = 1'b0;
        check("rstmid/no_time_out", pulses, 0);
        start_delay = 1'b1;
        step();
        start_delay = 1'b0;
        check("rstmid/fresh_delay", int'(delay_ms), 251);
        check("rstmid/fresh_busy", int'(busy), 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
